// File: rtl/ap_pass_sequencer.sv
// Bit-serial ADD/SUB pass sequencer for the associative processor array.
// Walks A/B bit columns LSB first and issues four compare/write passes per bit.
//
// Ports:
//   clk, rst_In        - clock and synchronous active-high reset
//   start, op, nbits   - request; op 0=ADD (B+=A), 1=SUB (B-=A); width to process
//   busy, done         - operation in flight; one-cycle completion pulse
//   bit_idx            - current A/B column
//   key, mask          - compare key/mask over {C,B,A}
//   pass               - pass number 1..4 (0 when idle or on the clear pass)
//   cmp_en, wr_en      - compare cycle / write cycle strobes
//   wr_data            - {C,B} value written to tagged rows
//
// Optional feature: define AP_CARRY_CLEAR_EN to zero the carry column C with a
// compare-all/write pass before bit 0. Without it C keeps its value, which
// allows multi-word chaining.
module ap_pass_sequencer #(
  parameter int WORD_WIDTH = 16,
  parameter int IDX_W      = $clog2(WORD_WIDTH)
) (
  input  logic             clk,
  input  logic             rst_In,
  input  logic             start,
  input  logic             op,
  input  logic [IDX_W:0]   nbits,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] bit_idx,
  output logic [2:0]       key,
  output logic [2:0]       mask,
  output logic [2:0]       pass,
  output logic             cmp_en,
  output logic             wr_en,
  output logic [1:0]       wr_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR_CMP,
    S_CLR_WR,
    S_CMP,
    S_WR,
    S_DONE
  } state_e;

  localparam int NBW = IDX_W + 1;
  localparam logic [IDX_W:0] NB_MAX = NBW'(WORD_WIDTH);

`ifdef AP_CARRY_CLEAR_EN
  localparam logic CLR_EN = 1'b1;
`else
  localparam logic CLR_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [IDX_W:0]   nb_q, nb_d;
  logic [IDX_W-1:0] bit_q, bit_d;
  logic [1:0]       pc_q, pc_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [2:0]       key_q, key_d;
  logic [2:0]       mask_q, mask_d;
  logic [2:0]       pass_q, pass_d;
  logic             cmp_en_q, cmp_en_d;
  logic             wr_en_q, wr_en_d;
  logic [1:0]       wr_data_q, wr_data_d;

  logic [IDX_W:0]   nb_clamp;
  logic             bit_last;
  logic [4:0]       row;

  // {key[2:0], wr_data[1:0]} for each op/pass. The order matters: every
  // write yields a pattern already consumed or left unchanged.
  function automatic logic [4:0] pass_row(input logic sub,
                                          input logic [1:0] p);
    logic [4:0] r;
    r = 5'b0;
    unique case ({sub, p})
      3'b000: r = {3'b011, 2'b10};
      3'b001: r = {3'b001, 2'b01};
      3'b010: r = {3'b100, 2'b01};
      3'b011: r = {3'b110, 2'b10};
      3'b100: r = {3'b001, 2'b11};
      3'b101: r = {3'b011, 2'b00};
      3'b110: r = {3'b110, 2'b00};
      3'b111: r = {3'b100, 2'b11};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  assign nb_clamp = (nbits > NB_MAX) ? NB_MAX : nbits;
  assign bit_last = ({1'b0, bit_q} + NBW'(1)) >= nb_q;
  assign row      = pass_row(op_q, pc_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    nb_d    = nb_q;
    bit_d   = bit_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          nb_d  = nb_clamp;
          bit_d = '0;
          pc_d  = '0;
          if (nb_clamp == '0)
            state_d = S_DONE;
          else if (CLR_EN)
            state_d = S_CLR_CMP;
          else
            state_d = S_CMP;
        end
      end
      S_CLR_CMP: state_d = S_CLR_WR;
      S_CLR_WR:  state_d = S_CMP;
      S_CMP:     state_d = S_WR;
      S_WR: begin
        if (pc_q != 2'd3) begin
          pc_d    = pc_q + 2'd1;
          state_d = S_CMP;
        end else if (!bit_last) begin
          bit_d   = bit_q + IDX_W'(1);
          pc_d    = '0;
          state_d = S_CMP;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the current state and registered, so they
  // trail the state register by one cycle.
  always_comb begin
    busy_d    = state_q != S_IDLE;
    done_d    = state_q == S_DONE;
    cmp_en_d  = (state_q == S_CMP) || (state_q == S_CLR_CMP);
    wr_en_d   = (state_q == S_WR) || (state_q == S_CLR_WR);
    bit_idx_d = '0;
    key_d     = '0;
    mask_d    = '0;
    pass_d    = '0;
    wr_data_d = '0;
    if (state_q == S_CMP) begin
      key_d  = row[4:2];
      mask_d = 3'b111;
    end
    if (state_q == S_WR)
      wr_data_d = row[1:0];
    if ((state_q == S_CMP) || (state_q == S_WR)) begin
      pass_d    = {1'b0, pc_q} + 3'd1;
      bit_idx_d = bit_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_In) begin
      state_q   <= S_IDLE;
      op_q      <= 1'b0;
      nb_q      <= '0;
      bit_q     <= '0;
      pc_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_idx_q <= '0;
      key_q     <= '0;
      mask_q    <= '0;
      pass_q    <= '0;
      cmp_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      nb_q      <= nb_d;
      bit_q     <= bit_d;
      pc_q      <= pc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bit_idx_q <= bit_idx_d;
      key_q     <= key_d;
      mask_q    <= mask_d;
      pass_q    <= pass_d;
      cmp_en_q  <= cmp_en_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_idx = bit_idx_q;
  assign key     = key_q;
  assign mask    = mask_q;
  assign pass    = pass_q;
  assign cmp_en  = cmp_en_q;
  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_ap_pass_sequencer.sv
// Directed bench for ap_pass_sequencer with a two-row cell array model.
// Expected values are hand-computed arithmetic results and cycle counts.
module tb_ap_pass_sequencer;

`ifdef AP_CARRY_CLEAR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_In;
  logic       start;
  logic       op;
  logic [4:0] nbits;
  logic       busy;
  logic       done;
  logic [3:0] bit_idx;
  logic [2:0] key;
  logic [2:0] mask;
  logic [2:0] pass;
  logic       cmp_en;
  logic       wr_en;
  logic [1:0] wr_data;

  ap_pass_sequencer #(.WORD_WIDTH(16), .IDX_W(4)) dut (
    .clk(clk), .rst_In(rst_In), .start(start), .op(op), .nbits(nbits),
    .busy(busy), .done(done), .bit_idx(bit_idx), .key(key), .mask(mask),
    .pass(pass), .cmp_en(cmp_en), .wr_en(wr_en), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] ma [2];
  logic [15:0] mb [2];
  logic        mc [2];
  logic        tg [2];
  logic [2:0]  keys [$];
  int          n_cmp, n_wr, both_err, max_bit;
  logic [9:0]  first_out;

  task automatic clear_stats();
    n_cmp = 0; n_wr = 0; both_err = 0; max_bit = 0;
    keys.delete();
    tg[0] = 1'b0; tg[1] = 1'b0;
  endtask

  // Cell array model: compare sets tags, write updates tagged rows.
  task automatic obs();
    if (cmp_en && wr_en) both_err++;
    if (cmp_en) begin
      n_cmp++;
      for (int r = 0; r < 2; r++)
        tg[r] = ((({mc[r], mb[r][bit_idx], ma[r][bit_idx]}) ^ key)
                 & mask) == 3'b000;
      if (pass != 3'd0) keys.push_back(key);
    end
    if (wr_en) begin
      n_wr++;
      for (int r = 0; r < 2; r++)
        if (tg[r]) begin
          mc[r] = wr_data[1];
          if (pass != 3'd0) mb[r][bit_idx] = wr_data[0];
        end
    end
    if ((cmp_en || wr_en) && pass != 3'd0 && int'(bit_idx) > max_bit)
      max_bit = int'(bit_idx);
  endtask

  task automatic run_op(input logic o, input logic [4:0] n, input int budget,
                        output int first_i, output int done_i);
    clear_stats();
    first_i = 0; done_i = 0; first_out = '0;
    @(negedge clk);
    op = o; nbits = n; start = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      start = 1'b0; op = ~o; nbits = 5'd3;
      obs();
      if (busy && first_i == 0) begin
        first_i = i;
        first_out = {cmp_en, mask, key, pass};
      end
      if (done) begin
        done_i = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_In = 1'b1; start = 1'b1; op = 1'b1; nbits = 5'd5;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, bit_idx, key, mask, pass, cmp_en, wr_en, wr_data} !== 19'b0) begin
      miscompares++;
      $display("FAIL reset_outs got %0h exp 0",
               {busy, done, bit_idx, key, mask, pass, cmp_en, wr_en, wr_data});
    end
    rst_In = 1'b0; start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, cmp_en, wr_en} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_idle got %0h exp 0", {busy, done, cmp_en, wr_en});
    end
  endtask

  task automatic test_add();
    int f, d;
    ma = '{16'd3, 16'd15};
    mb = '{16'd5, 16'd1};
    mc = (CLR == 1) ? '{1'b1, 1'b1} : '{1'b0, 1'b0};
    run_op(1'b0, 5'd4, 200, f, d);
    vectors++;
    if (f !== 2) begin
      miscompares++;
      $display("FAIL add_latency got %0d exp 2", f);
    end
    vectors++;
    if (d == 0 || (d - f + 1) !== 32 + 2*CLR + 1) begin
      miscompares++;
      $display("FAIL add_length got %0d exp %0d", d - f + 1, 32 + 2*CLR + 1);
    end
    vectors++;
    if (first_out !== ((CLR == 1) ? 10'b1_000_000_000 : 10'b1_111_011_001)) begin
      miscompares++;
      $display("FAIL add_first got %0b", first_out);
    end
    vectors++;
    if ({mc[0], mb[0]} !== {1'b0, 16'd8}) begin
      miscompares++;
      $display("FAIL add_row0 got %0h exp 8", {mc[0], mb[0]});
    end
    vectors++;
    if ({mc[1], mb[1]} !== {1'b1, 16'd0}) begin
      miscompares++;
      $display("FAIL add_row1 got %0h exp 10000", {mc[1], mb[1]});
    end
    vectors++;
    if (n_cmp !== 16 + CLR || n_wr !== 16 + CLR || both_err !== 0) begin
      miscompares++;
      $display("FAIL add_strobes got cmp %0d wr %0d both %0d exp %0d",
               n_cmp, n_wr, both_err, 16 + CLR);
    end
  endtask

  task automatic test_sub();
    int f, d, kerr;
    logic [2:0] exp_k [4];
    exp_k = '{3'b001, 3'b011, 3'b110, 3'b100};
    ma = '{16'd7, 16'd0};
    mb = '{16'd2, 16'd0};
    mc = '{1'b0, 1'b0};
    run_op(1'b1, 5'd8, 300, f, d);
    vectors++;
    if ({mc[0], mb[0]} !== {1'b1, 16'h00FB}) begin
      miscompares++;
      $display("FAIL sub_row0 got %0h exp 100fb", {mc[0], mb[0]});
    end
    vectors++;
    if ({mc[1], mb[1]} !== 17'd0) begin
      miscompares++;
      $display("FAIL sub_row1 got %0h exp 0", {mc[1], mb[1]});
    end
    kerr = 0;
    for (int i = 0; i < keys.size(); i++)
      if (keys[i] !== exp_k[i % 4]) kerr++;
    vectors++;
    if (keys.size() !== 32 || kerr !== 0) begin
      miscompares++;
      $display("FAIL sub_keys got n %0d bad %0d exp n 32 bad 0",
               keys.size(), kerr);
    end
    vectors++;
    if (d == 0 || (d - f + 1) !== 64 + 2*CLR + 1) begin
      miscompares++;
      $display("FAIL sub_length got %0d exp %0d", d - f + 1, 64 + 2*CLR + 1);
    end
  endtask

  task automatic test_zero();
    int f, d;
    ma = '{16'd0, 16'd0}; mb = '{16'd0, 16'd0}; mc = '{1'b0, 1'b0};
    run_op(1'b0, 5'd0, 20, f, d);
    vectors++;
    if (d !== 2 || f !== 2) begin
      miscompares++;
      $display("FAIL zero_done got done %0d busy %0d exp 2 2", d, f);
    end
    vectors++;
    if (n_cmp !== 0 || n_wr !== 0) begin
      miscompares++;
      $display("FAIL zero_strobes got cmp %0d wr %0d exp 0 0", n_cmp, n_wr);
    end
  endtask

  task automatic test_clamp();
    int f, d;
    ma = '{16'hFFFF, 16'h1234}; mb = '{16'h0001, 16'h4321};
    mc = '{1'b0, 1'b0};
    run_op(1'b0, 5'd20, 400, f, d);
    vectors++;
    if (max_bit !== 15) begin
      miscompares++;
      $display("FAIL clamp_lastbit got %0d exp 15", max_bit);
    end
    vectors++;
    if (n_cmp !== 64 + CLR || n_wr !== 64 + CLR) begin
      miscompares++;
      $display("FAIL clamp_passes got %0d %0d exp %0d", n_cmp, n_wr, 64 + CLR);
    end
    vectors++;
    if (d == 0 || (d - f + 1) !== 128 + 2*CLR + 1) begin
      miscompares++;
      $display("FAIL clamp_length got %0d exp %0d", d - f + 1, 128 + 2*CLR + 1);
    end
    vectors++;
    if ({mc[0], mb[0], mc[1], mb[1]} !== {1'b1, 16'h0000, 1'b0, 16'h5555}) begin
      miscompares++;
      $display("FAIL clamp_data got %0h %0h", mb[0], mb[1]);
    end
  endtask

  task automatic test_abort();
    logic       hit;
    logic [2:0] k11;
    int         seen;
    hit = 1'b0; k11 = 3'b000;
    @(negedge clk);
    op = 1'b0; nbits = 5'd8; start = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      start = (i == 6);
      op = (i == 6);
      if (cmp_en && pass == 3'd1 && bit_idx == 4'd1) k11 = key;
      if (cmp_en && pass == 3'd3 && bit_idx == 4'd2) begin
        hit = 1'b1;
        break;
      end
    end
    start = 1'b0;
    vectors++;
    if (hit !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_reach got %0b exp 1", hit);
    end
    vectors++;
    if (k11 !== 3'b011) begin
      miscompares++;
      $display("FAIL abort_ignore_start got %0b exp 011", k11);
    end
    rst_In = 1'b1;
    @(negedge clk);
    rst_In = 1'b0;
    vectors++;
    if ({busy, done, bit_idx, key, mask, pass, cmp_en, wr_en, wr_data} !== 19'b0) begin
      miscompares++;
      $display("FAIL abort_outs got %0h exp 0",
               {busy, done, bit_idx, key, mask, pass, cmp_en, wr_en, wr_data});
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy || cmp_en || wr_en) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL abort_quiet got %0d exp 0", seen);
    end
  endtask

  task automatic test_chain();
    int f, d;
    ma = '{16'd0, 16'd0}; mb = '{16'd0, 16'd0}; mc = '{1'b1, 1'b1};
    run_op(1'b0, 5'd1, 50, f, d);
    vectors++;
    if ({mc[0], mb[0][0]} !== ((CLR == 1) ? 2'b00 : 2'b01)) begin
      miscompares++;
      $display("FAIL chain_result got %0b", {mc[0], mb[0][0]});
    end
    vectors++;
    if (first_out !== ((CLR == 1) ? 10'b1_000_000_000 : 10'b1_111_011_001)) begin
      miscompares++;
      $display("FAIL chain_first got %0b", first_out);
    end
  endtask

  task automatic test_back_to_back();
    int  f, d;
    logic got;
    ma = '{16'd1, 16'd0}; mb = '{16'd1, 16'd0}; mc = '{1'b0, 1'b0};
    run_op(1'b0, 5'd1, 50, f, d);
    start = 1'b1; op = 1'b0; nbits = 5'd1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_gap got %0b exp 00", {busy, done});
    end
    @(negedge clk);
    vectors++;
    if ({busy, cmp_en} !== 2'b11) begin
      miscompares++;
      $display("FAIL b2b_accept got %0b exp 11", {busy, cmp_en});
    end
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    vectors++;
    if (got !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done got %0b exp 1", got);
    end
  endtask

  initial begin
    rst_In = 1'b1; start = 1'b0; op = 1'b0; nbits = '0;
    test_reset();
    test_add();
    test_sub();
    test_zero();
    test_clamp();
    test_abort();
    test_chain();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
